// File: rtl/ctrl_pipe_stage_pkg.sv
// Shared decode constants and forwarding-select codes for the pipeline control stage.
package ctrl_pipe_stage_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/ctrl_pipe_stage_fwd_unit.sv
// EX-stage operand forwarding selects; EX/MEM beats MEM/WB, x0 never forwards.
module fwd_unit
  import ctrl_pipe_stage_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] ex_rs1_i,
  input  logic [RA_W-1:0] ex_rs2_i,
  input  logic            mem_regwrite_i,
  input  logic [RA_W-1:0] mem_rd_i,
  input  logic            wb_regwrite_i,
  input  logic [RA_W-1:0] wb_rd_i,
  output logic [1:0]      fwd_a_o,
  output logic [1:0]      fwd_b_o
);

  function automatic fwd_sel_e pick(input logic [RA_W-1:0] rs,
                                    input logic            mem_we,
                                    input logic [RA_W-1:0] mem_rd,
                                    input logic            wb_we,
                                    input logic [RA_W-1:0] wb_rd);
    if (mem_we && (mem_rd != '0) && (mem_rd == rs))
      return FWD_MEM;
    else if (wb_we && (wb_rd != '0) && (wb_rd == rs))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

  always_comb begin
    fwd_a_o = pick(ex_rs1_i, mem_regwrite_i, mem_rd_i, wb_regwrite_i, wb_rd_i);
    fwd_b_o = pick(ex_rs2_i, mem_regwrite_i, mem_rd_i, wb_regwrite_i, wb_rd_i);
  end

endmodule

// File: rtl/ctrl_pipe_stage.sv
// Carries the decoder control bundle through ID/EX, EX/MEM and MEM/WB,
// inserting bubbles on load-use hazards and taken branches.
module ctrl_pipe_stage
  import ctrl_pipe_stage_pkg::*;
#(
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [RA_W-1:0]    id_rs1,
  input  logic [RA_W-1:0]    id_rs2,
  input  logic [RA_W-1:0]    id_rd,
  input  logic [ALUOP_W-1:0] id_ALUOp,
  input  logic               id_Branch,
  input  logic               id_MemRead,
  input  logic               id_MemtoReg,
  input  logic               id_MemWrite,
  input  logic               id_ALUSrc,
  input  logic               id_RegWrite,
  input  logic               ex_br_taken,
  output logic               stall,
  output logic               flush,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic               ex_ALUSrc,
  output logic               ex_Branch,
  output logic [RA_W-1:0]    ex_rd,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               mem_MemRead,
  output logic               mem_MemWrite,
  output logic               mem_MemtoReg,
  output logic               mem_RegWrite,
  output logic [RA_W-1:0]    mem_rd,
  output logic               wb_MemtoReg,
  output logic               wb_RegWrite,
  output logic [RA_W-1:0]    wb_rd
);

  logic [ALUOP_W-1:0] ex_aluop_q, ex_aluop_d;
  logic               ex_branch_q, ex_branch_d;
  logic               ex_memread_q, ex_memread_d;
  logic               ex_memtoreg_q, ex_memtoreg_d;
  logic               ex_memwrite_q, ex_memwrite_d;
  logic               ex_alusrc_q, ex_alusrc_d;
  logic               ex_regwrite_q, ex_regwrite_d;
  logic [RA_W-1:0]    ex_rd_q, ex_rd_d;
  logic [RA_W-1:0]    ex_rs1_q, ex_rs1_d;
  logic [RA_W-1:0]    ex_rs2_q, ex_rs2_d;

  logic               mem_memread_q, mem_memwrite_q, mem_memtoreg_q, mem_regwrite_q;
  logic [RA_W-1:0]    mem_rd_q;
  logic               wb_memtoreg_q, wb_regwrite_q;
  logic [RA_W-1:0]    wb_rd_q;

  logic flush_c, load_use_c, stall_c, bubble_c;

  always_comb begin
    flush_c    = ex_branch_q & ex_br_taken;
    load_use_c = ex_memread_q & (ex_rd_q != '0) & id_valid &
                 ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));
    stall_c    = load_use_c & ~flush_c;
    bubble_c   = ~id_valid | stall_c | flush_c;
  end

  // Bubble muxes every field so nothing from an invalid ID slot reaches a register.
  always_comb begin
    ex_aluop_d    = '0;
    ex_branch_d   = 1'b0;
    ex_memread_d  = 1'b0;
    ex_memtoreg_d = 1'b0;
    ex_memwrite_d = 1'b0;
    ex_alusrc_d   = 1'b0;
    ex_regwrite_d = 1'b0;
    ex_rd_d       = '0;
    ex_rs1_d      = '0;
    ex_rs2_d      = '0;
    if (!bubble_c) begin
      ex_aluop_d    = id_ALUOp;
      ex_branch_d   = id_Branch;
      ex_memread_d  = id_MemRead;
      ex_memtoreg_d = id_MemtoReg & id_RegWrite;
      ex_memwrite_d = id_MemWrite;
      ex_alusrc_d   = id_ALUSrc;
      ex_regwrite_d = id_RegWrite;
      ex_rd_d       = id_rd;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_aluop_q     <= '0;
      ex_branch_q    <= 1'b0;
      ex_memread_q   <= 1'b0;
      ex_memtoreg_q  <= 1'b0;
      ex_memwrite_q  <= 1'b0;
      ex_alusrc_q    <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_rd_q        <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_rd_q       <= '0;
      wb_memtoreg_q  <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_rd_q        <= '0;
    end else begin
      ex_aluop_q     <= ex_aluop_d;
      ex_branch_q    <= ex_branch_d;
      ex_memread_q   <= ex_memread_d;
      ex_memtoreg_q  <= ex_memtoreg_d;
      ex_memwrite_q  <= ex_memwrite_d;
      ex_alusrc_q    <= ex_alusrc_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_rd_q        <= ex_rd_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      mem_memread_q  <= ex_memread_q;
      mem_memwrite_q <= ex_memwrite_q;
      mem_memtoreg_q <= ex_memtoreg_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_rd_q       <= ex_rd_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_rd_q        <= mem_rd_q;
    end
  end

  fwd_unit #(.RA_W(RA_W)) u_fwd (
    .ex_rs1_i       (ex_rs1_q),
    .ex_rs2_i       (ex_rs2_q),
    .mem_regwrite_i (mem_regwrite_q),
    .mem_rd_i       (mem_rd_q),
    .wb_regwrite_i  (wb_regwrite_q),
    .wb_rd_i        (wb_rd_q),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b)
  );

  assign stall        = stall_c;
  assign flush        = flush_c;
  assign ex_ALUOp     = ex_aluop_q;
  assign ex_ALUSrc    = ex_alusrc_q;
  assign ex_Branch    = ex_branch_q;
  assign ex_rd        = ex_rd_q;
  assign mem_MemRead  = mem_memread_q;
  assign mem_MemWrite = mem_memwrite_q;
  assign mem_MemtoReg = mem_memtoreg_q;
  assign mem_RegWrite = mem_regwrite_q;
  assign mem_rd       = mem_rd_q;
  assign wb_MemtoReg  = wb_memtoreg_q;
  assign wb_RegWrite  = wb_regwrite_q;
  assign wb_rd        = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Bench for ctrl_pipe_stage: directed hazard scenarios plus randomized traffic
// compared every cycle against a slot-array pipeline model.
module tb_ctrl_pipe_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] id_ALUOp;
  logic       id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite;
  logic       ex_br_taken;
  logic       stall, flush;
  logic [1:0] ex_ALUOp;
  logic       ex_ALUSrc, ex_Branch;
  logic [4:0] ex_rd;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite;
  logic [4:0] mem_rd;
  logic       wb_MemtoReg, wb_RegWrite;
  logic [4:0] wb_rd;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  ctrl_pipe_stage #(.RA_W(5), .ALUOP_W(2)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ALUOp(id_ALUOp),
    .id_Branch(id_Branch), .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg),
    .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite),
    .ex_br_taken(ex_br_taken), .stall(stall), .flush(flush),
    .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch), .ex_rd(ex_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_MemtoReg(mem_MemtoReg),
    .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd),
    .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd)
  );

  // Model: one record per in-flight instruction; index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic [1:0] aluop;
    logic       branch, memread, memtoreg, memwrite, alusrc, regwrite;
    logic [4:0] rd, rs1, rs2;
  } slot_t;

  slot_t pipe [3];

  function automatic bit m_flush();
    return pipe[0].branch && ex_br_taken;
  endfunction

  function automatic bit m_stall();
    if (m_flush()) return 1'b0;
    return pipe[0].memread && pipe[0].rd != 0 && id_valid &&
           (pipe[0].rd == id_rs1 || pipe[0].rd == id_rs2);
  endfunction

  function automatic int m_fwd(input logic [4:0] rs);
    for (int s = 1; s <= 2; s++)
      if (pipe[s].regwrite && pipe[s].rd != 0 && pipe[s].rd == rs)
        return (s == 1) ? 2 : 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    slot_t nxt;
    nxt = '0;
    if (id_valid && !m_stall() && !m_flush()) begin
      nxt.aluop    = id_ALUOp;
      nxt.branch   = id_Branch;
      nxt.memread  = id_MemRead;
      nxt.memtoreg = id_MemtoReg && id_RegWrite;
      nxt.memwrite = id_MemWrite;
      nxt.alusrc   = id_ALUSrc;
      nxt.regwrite = id_RegWrite;
      nxt.rd       = id_rd;
      nxt.rs1      = id_rs1;
      nxt.rs2      = id_rs2;
    end
    if (reset) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
    end else begin
      for (int i = 2; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = nxt;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m.stall",        int'(stall),        int'(m_stall()));
      chk("m.flush",        int'(flush),        int'(m_flush()));
      chk("m.ex_ALUOp",     int'(ex_ALUOp),     int'(pipe[0].aluop));
      chk("m.ex_ALUSrc",    int'(ex_ALUSrc),    int'(pipe[0].alusrc));
      chk("m.ex_Branch",    int'(ex_Branch),    int'(pipe[0].branch));
      chk("m.ex_rd",        int'(ex_rd),        int'(pipe[0].rd));
      chk("m.fwd_a",        int'(fwd_a),        m_fwd(pipe[0].rs1));
      chk("m.fwd_b",        int'(fwd_b),        m_fwd(pipe[0].rs2));
      chk("m.mem_MemRead",  int'(mem_MemRead),  int'(pipe[1].memread));
      chk("m.mem_MemWrite", int'(mem_MemWrite), int'(pipe[1].memwrite));
      chk("m.mem_MemtoReg", int'(mem_MemtoReg), int'(pipe[1].memtoreg));
      chk("m.mem_RegWrite", int'(mem_RegWrite), int'(pipe[1].regwrite));
      chk("m.mem_rd",       int'(mem_rd),       int'(pipe[1].rd));
      chk("m.wb_MemtoReg",  int'(wb_MemtoReg),  int'(pipe[2].memtoreg));
      chk("m.wb_RegWrite",  int'(wb_RegWrite),  int'(pipe[2].regwrite));
      chk("m.wb_rd",        int'(wb_rd),        int'(pipe[2].rd));
    end
  end

  // Inputs change only at posedge+1 or right after a probe at posedge+3.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    #2;
  endtask

  task automatic set_id(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit [4:0] rd, input bit [1:0] op, input bit br,
                        input bit mr, input bit m2r, input bit mw, input bit as,
                        input bit rw);
    id_valid = v;  id_rs1 = rs1;  id_rs2 = rs2;  id_rd = rd;  id_ALUOp = op;
    id_Branch = br; id_MemRead = mr; id_MemtoReg = m2r; id_MemWrite = mw;
    id_ALUSrc = as; id_RegWrite = rw;
  endtask

  task automatic rtype(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
    set_id(1, rs1, rs2, rd, 2'b10, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic load(input bit [4:0] rd, input bit [4:0] rs1);
    set_id(1, rs1, 5'd0, rd, 2'b00, 0, 1, 1, 0, 1, 1);
  endtask

  task automatic nop();
    set_id(0, 5'($urandom), 5'($urandom), 5'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
  endtask

  task automatic drain();
    nop();
    ex_br_taken = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    // Reset with garbage on the ID bundle
    reset = 1'b1;
    ex_br_taken = 1'($urandom);
    set_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
    tick();
    cmp_en = 1'b1;
    tick();
    probe();
    chk("rst.ex_rd",    int'(ex_rd), 0);
    chk("rst.ex_ALUOp", int'(ex_ALUOp), 0);
    chk("rst.mem_rd",   int'(mem_rd), 0);
    chk("rst.wb_RegWrite", int'(wb_RegWrite), 0);
    chk("rst.stall",    int'(stall), 0);
    chk("rst.flush",    int'(flush), 0);
    chk("rst.fwd_a",    int'(fwd_a), 0);
    reset = 1'b0;
    ex_br_taken = 1'b0;
    rtype(5, 1, 2);
    tick();
    nop();
    probe();
    chk("lat.ex_ALUOp", int'(ex_ALUOp), 2);
    chk("lat.ex_rd",    int'(ex_rd), 5);
    tick();
    tick();
    probe();
    chk("lat.wb_RegWrite", int'(wb_RegWrite), 1);
    chk("lat.wb_rd",       int'(wb_rd), 5);

    // Load-use: one stall, bubble, then MEM/WB forward
    drain();
    load(7, 1);
    tick();
    rtype(8, 7, 2);
    probe();
    chk("lu.stall1", int'(stall), 1);
    tick();
    probe();
    chk("lu.stall2",   int'(stall), 0);
    chk("lu.bubble_rd", int'(ex_rd), 0);
    chk("lu.bubble_mr", int'(mem_MemRead), 1);
    tick();
    nop();
    probe();
    chk("lu.ex_rd", int'(ex_rd), 8);
    chk("lu.fwd_a", int'(fwd_a), 1);

    // EX/MEM forward on both operands; rd=x0 never forwards
    drain();
    rtype(3, 1, 2);
    tick();
    rtype(9, 3, 3);
    tick();
    nop();
    probe();
    chk("fw.fwd_a", int'(fwd_a), 2);
    chk("fw.fwd_b", int'(fwd_b), 2);
    drain();
    rtype(0, 1, 2);
    tick();
    rtype(9, 0, 0);
    tick();
    nop();
    probe();
    chk("x0.fwd_a", int'(fwd_a), 0);
    chk("x0.fwd_b", int'(fwd_b), 0);

    // Two writers to x4: the younger (EX/MEM) wins
    drain();
    rtype(4, 1, 2);
    tick();
    rtype(4, 2, 1);
    tick();
    rtype(10, 4, 1);
    tick();
    nop();
    probe();
    chk("pri.fwd_a", int'(fwd_a), 2);

    // Taken branch overrides a load-use stall
    drain();
    set_id(1, 5'd1, 5'd2, 5'd6, 2'b01, 1, 1, 0, 0, 0, 0);
    tick();
    rtype(11, 6, 0);
    ex_br_taken = 1'b1;
    probe();
    chk("br.flush", int'(flush), 1);
    chk("br.stall", int'(stall), 0);
    tick();
    ex_br_taken = 1'b0;
    probe();
    chk("br.bubble_rd", int'(ex_rd), 0);
    chk("br.bubble_br", int'(ex_Branch), 0);
    rtype(12, 1, 2);
    tick();
    ex_br_taken = 1'b1;
    nop();
    probe();
    chk("nb.flush", int'(flush), 0);
    ex_br_taken = 1'b0;

    // Store with MemtoReg set but RegWrite clear is sanitised
    drain();
    set_id(1, 5'd1, 5'd2, 5'd13, 2'b00, 0, 0, 1, 1, 1, 0);
    tick();
    nop();
    tick();
    probe();
    chk("st.mem_MemtoReg", int'(mem_MemtoReg), 0);
    chk("st.mem_MemWrite", int'(mem_MemWrite), 1);
    chk("st.mem_RegWrite", int'(mem_RegWrite), 0);

    // Reset while a load sits in MEM
    drain();
    load(7, 1);
    tick();
    nop();
    tick();
    probe();
    chk("rm.mem_MemRead", int'(mem_MemRead), 1);
    chk("rm.mem_rd",      int'(mem_rd), 7);
    reset = 1'b1;
    tick();
    probe();
    chk("rm.mem_MemRead2", int'(mem_MemRead), 0);
    chk("rm.mem_rd2",      int'(mem_rd), 0);
    chk("rm.wb_RegWrite",  int'(wb_RegWrite), 0);
    chk("rm.wb_rd",        int'(wb_rd), 0);
    reset = 1'b0;

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset       = ($urandom_range(0, 99) == 0);
      ex_br_taken = 1'($urandom);
      set_id($urandom_range(0, 3) != 0,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
             ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
    end
    tick();
    tick();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
